// File: rtl/icache_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-cache fetch unit.
// Holds the controller state encoding and the default cache geometry.
package icache_fetch_unit_pkg;

    localparam int IC_INDEX_BITS_DEF = 6;
    localparam int IC_ADDR_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IC_STAT_IDLE    = 2'd0,
        IC_STAT_MISS    = 2'd1,
        IC_STAT_DISCARD = 2'd2
    } ic_state_t;

endpackage

// File: rtl/icache_tag_data_array.sv
// Valid/tag/data storage for a direct-mapped, one-word-per-line cache.
// Latency: combinational read, write lands on the next clk_in edge.
// Backpressure: none; the caller gates wr_en.
module icache_tag_data_array
    import icache_fetch_unit_pkg::*;
#(
    parameter int IDX_BITS = IC_INDEX_BITS_DEF,
    parameter int TAG_BITS = IC_ADDR_WIDTH_DEF - IC_INDEX_BITS_DEF - 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [IDX_BITS-1:0] rd_idx,
    input  logic [TAG_BITS-1:0] rd_tag,
    output logic                rd_hit,
    output logic [31:0]         rd_word,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [31:0]         wr_word
);

    localparam int LINES = 1 << IDX_BITS;

    logic [LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Tag and data contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_word;
        end
    end

    assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_word = data_q[rd_idx];

endmodule

// File: rtl/icache_fetch_unit.sv
// Fetch-side I-cache: 1-cycle hit, miss = memory latency + 2 cycles; optional ICACHE_PERF_CNT_EN counters.
// Backpressure: single outstanding miss; requests during MISS/DISCARD are ignored, rdy_in=0 freezes all.
module icache_fetch_unit
    import icache_fetch_unit_pkg::*;
#(
    parameter int IC_INDEX_BITS = IC_INDEX_BITS_DEF,
    parameter int ADDR_WIDTH    = IC_ADDR_WIDTH_DEF
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clr_in,
    input  logic                  if_to_ic_request,
    input  logic [ADDR_WIDTH-1:0] if_to_ic_pc,
    output logic                  ic_to_if_rdy,
    output logic [31:0]           ic_to_if_inst,
    output logic                  ic_to_mc_request,
    output logic [ADDR_WIDTH-1:0] ic_to_mc_pc,
    input  logic                  mc_to_ic_rdy,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0]           ic_hit_cnt,
    output logic [31:0]           ic_miss_cnt,
`endif
    input  logic [31:0]           mc_dout
);

    localparam int TAG_BITS = ADDR_WIDTH - IC_INDEX_BITS - 2;

    ic_state_t               state_q, state_d;
    logic                    if_rdy_q, if_rdy_d;
    logic [31:0]             inst_q, inst_d;
    logic                    mc_req_q, mc_req_d;
    logic [ADDR_WIDTH-3:0]   mc_pc_q, mc_pc_d;

    logic                    rd_hit;
    logic [31:0]             rd_word;
    logic                    wr_en;
    logic                    lookup;
    logic [1:0]              pc_lo_unused;

    assign pc_lo_unused = if_to_ic_pc[1:0];
    assign lookup       = rdy_in && (state_q == IC_STAT_IDLE) && if_to_ic_request && !clr_in;

    icache_tag_data_array #(
        .IDX_BITS (IC_INDEX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_array (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rd_idx  (if_to_ic_pc[IC_INDEX_BITS+1:2]),
        .rd_tag  (if_to_ic_pc[ADDR_WIDTH-1:IC_INDEX_BITS+2]),
        .rd_hit  (rd_hit),
        .rd_word (rd_word),
        .wr_en   (wr_en),
        .wr_idx  (mc_pc_q[IC_INDEX_BITS-1:0]),
        .wr_tag  (mc_pc_q[ADDR_WIDTH-3:IC_INDEX_BITS]),
        .wr_word (mc_dout)
    );

    always_comb begin
        state_d  = state_q;
        if_rdy_d = 1'b0;
        inst_d   = inst_q;
        mc_req_d = mc_req_q;
        mc_pc_d  = mc_pc_q;
        wr_en    = 1'b0;
        case (state_q)
            IC_STAT_IDLE: begin
                if (lookup) begin
                    if (rd_hit) begin
                        if_rdy_d = 1'b1;
                        inst_d   = rd_word;
                    end else begin
                        mc_req_d = 1'b1;
                        mc_pc_d  = if_to_ic_pc[ADDR_WIDTH-1:2];
                        state_d  = IC_STAT_MISS;
                    end
                end
            end
            IC_STAT_MISS: begin
                if (mc_to_ic_rdy) begin
                    wr_en    = rdy_in;
                    mc_req_d = 1'b0;
                    state_d  = IC_STAT_IDLE;
                    // A flush landing on the return cycle still fills but must not deliver.
                    if (!clr_in) begin
                        if_rdy_d = 1'b1;
                        inst_d   = mc_dout;
                    end
                end else if (clr_in) begin
                    state_d = IC_STAT_DISCARD;
                end
            end
            IC_STAT_DISCARD: begin
                if (mc_to_ic_rdy) begin
                    wr_en    = rdy_in;
                    mc_req_d = 1'b0;
                    state_d  = IC_STAT_IDLE;
                end
            end
            default: state_d = IC_STAT_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IC_STAT_IDLE;
            if_rdy_q <= 1'b0;
            inst_q   <= '0;
            mc_req_q <= 1'b0;
            mc_pc_q  <= '0;
        end else if (rdy_in) begin
            state_q  <= state_d;
            if_rdy_q <= if_rdy_d;
            inst_q   <= inst_d;
            mc_req_q <= mc_req_d;
            mc_pc_q  <= mc_pc_d;
        end
    end

    assign ic_to_if_rdy     = if_rdy_q;
    assign ic_to_if_inst    = inst_q;
    assign ic_to_mc_request = mc_req_q;
    assign ic_to_mc_pc      = {mc_pc_q, 2'b00};

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (lookup) begin
            if (rd_hit) hit_cnt_d  = hit_cnt_q + 32'd1;
            else        miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign ic_hit_cnt  = hit_cnt_q;
    assign ic_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Directed bench for icache_fetch_unit: hits, misses, eviction, flush, stall, async reset.
// Inputs change and outputs are sampled 1 time unit after each rising clk_in edge.
module tb_icache_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clr_in;
    logic        if_to_ic_request;
    logic [31:0] if_to_ic_pc;
    logic        ic_to_if_rdy;
    logic [31:0] ic_to_if_inst;
    logic        ic_to_mc_request;
    logic [31:0] ic_to_mc_pc;
    logic        mc_to_ic_rdy;
    logic [31:0] mc_dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    icache_fetch_unit dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .clr_in           (clr_in),
        .if_to_ic_request (if_to_ic_request),
        .if_to_ic_pc      (if_to_ic_pc),
        .ic_to_if_rdy     (ic_to_if_rdy),
        .ic_to_if_inst    (ic_to_if_inst),
        .ic_to_mc_request (ic_to_mc_request),
        .ic_to_mc_pc      (ic_to_mc_pc),
        .mc_to_ic_rdy     (mc_to_ic_rdy),
        .mc_dout          (mc_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One fetch-stage transaction; on a miss the memory replies after lat cycles.
    task automatic fetch(input string nm, input logic [31:0] pc, input bit hit,
                         input logic [31:0] word, input int lat);
        if_to_ic_request = 1'b1;
        if_to_ic_pc      = pc;
        tick();
        if (hit) begin
            check({nm, ".hit_rdy"}, {31'd0, ic_to_if_rdy}, 32'd1);
            check({nm, ".hit_inst"}, ic_to_if_inst, word);
            check({nm, ".hit_noreq"}, {31'd0, ic_to_mc_request}, 32'd0);
        end else begin
            check({nm, ".miss_req"}, {31'd0, ic_to_mc_request}, 32'd1);
            check({nm, ".miss_pc"}, ic_to_mc_pc, {pc[31:2], 2'b00});
            check({nm, ".miss_nordy"}, {31'd0, ic_to_if_rdy}, 32'd0);
            for (int i = 1; i < lat; i++) begin
                tick();
                check({nm, ".req_held"}, {31'd0, ic_to_mc_request}, 32'd1);
            end
            mc_to_ic_rdy = 1'b1;
            mc_dout      = word;
            tick();
            mc_to_ic_rdy = 1'b0;
            mc_dout      = 32'h0;
            check({nm, ".fill_rdy"}, {31'd0, ic_to_if_rdy}, 32'd1);
            check({nm, ".fill_inst"}, ic_to_if_inst, word);
            check({nm, ".fill_req_drop"}, {31'd0, ic_to_mc_request}, 32'd0);
        end
        if_to_ic_request = 1'b0;
        tick();
        check({nm, ".rdy_pulse"}, {31'd0, ic_to_if_rdy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in           = 1'b1;
        rdy_in           = 1'b1;
        clr_in           = 1'b0;
        if_to_ic_request = 1'b0;
        if_to_ic_pc      = 32'h0;
        mc_to_ic_rdy     = 1'b0;
        mc_dout          = 32'h0;
        tick();
        tick();
        check("rst.if_rdy", {31'd0, ic_to_if_rdy}, 32'd0);
        check("rst.inst", ic_to_if_inst, 32'd0);
        check("rst.mc_req", {31'd0, ic_to_mc_request}, 32'd0);
        check("rst.mc_pc", ic_to_mc_pc, 32'd0);
        rst_in = 1'b0;
        tick();

        fetch("cold", 32'h0000_0000, 1'b0, 32'h0050_0093, 5);
        fetch("hit0", 32'h0000_0000, 1'b1, 32'h0050_0093, 0);

        fetch("evict100", 32'h0000_0100, 1'b0, 32'hDEAD_BEEF, 3);
        fetch("refill0", 32'h0000_0000, 1'b0, 32'h0050_0093, 2);
        fetch("hit0b", 32'h0000_0000, 1'b1, 32'h0050_0093, 0);

        // Flush in IDLE suppresses a same-cycle hit request.
        if_to_ic_request = 1'b1;
        if_to_ic_pc      = 32'h0;
        clr_in           = 1'b1;
        tick();
        if_to_ic_request = 1'b0;
        clr_in           = 1'b0;
        check("idle_clr.rdy", {31'd0, ic_to_if_rdy}, 32'd0);
        check("idle_clr.req", {31'd0, ic_to_mc_request}, 32'd0);

        // Flush mid-miss: request stays up, fill happens, nothing delivered.
        if_to_ic_request = 1'b1;
        if_to_ic_pc      = 32'h0000_0040;
        tick();
        check("flush.req", {31'd0, ic_to_mc_request}, 32'd1);
        if_to_ic_request = 1'b0;
        tick();
        clr_in = 1'b1;
        tick();
        clr_in = 1'b0;
        check("flush.req_held", {31'd0, ic_to_mc_request}, 32'd1);
        tick();
        mc_to_ic_rdy = 1'b1;
        mc_dout      = 32'h1234_5678;
        tick();
        mc_to_ic_rdy = 1'b0;
        check("flush.no_rdy", {31'd0, ic_to_if_rdy}, 32'd0);
        check("flush.req_drop", {31'd0, ic_to_mc_request}, 32'd0);
        tick();
        check("flush.no_rdy2", {31'd0, ic_to_if_rdy}, 32'd0);
        fetch("hit40", 32'h0000_0040, 1'b1, 32'h1234_5678, 0);

        // Stall with rdy_in low while a miss is outstanding.
        if_to_ic_request = 1'b1;
        if_to_ic_pc      = 32'h0000_0080;
        tick();
        check("stall.req", {31'd0, ic_to_mc_request}, 32'd1);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.req_frozen", {31'd0, ic_to_mc_request}, 32'd1);
            check("stall.pc_frozen", ic_to_mc_pc, 32'h0000_0080);
            check("stall.inst_frozen", ic_to_if_inst, 32'h1234_5678);
            check("stall.rdy_frozen", {31'd0, ic_to_if_rdy}, 32'd0);
        end
        rdy_in       = 1'b1;
        mc_to_ic_rdy = 1'b1;
        mc_dout      = 32'hCAFE_F00D;
        tick();
        mc_to_ic_rdy     = 1'b0;
        if_to_ic_request = 1'b0;
        check("stall.fill_rdy", {31'd0, ic_to_if_rdy}, 32'd1);
        check("stall.fill_inst", ic_to_if_inst, 32'hCAFE_F00D);
        tick();
        fetch("hit80", 32'h0000_0080, 1'b1, 32'hCAFE_F00D, 0);

        // Asynchronous reset between edges while a miss is outstanding.
        if_to_ic_request = 1'b1;
        if_to_ic_pc      = 32'h0000_00C0;
        tick();
        check("arst.req_before", {31'd0, ic_to_mc_request}, 32'd1);
        #2;
        rst_in = 1'b1;
        #1;
        check("arst.req_drop", {31'd0, ic_to_mc_request}, 32'd0);
        check("arst.pc_clear", ic_to_mc_pc, 32'd0);
        if_to_ic_request = 1'b0;
        tick();
        rst_in = 1'b0;
        tick();
        fetch("arst_remiss", 32'h0000_0000, 1'b0, 32'h0050_0093, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
